pipo_load_sequencer: RTL and testbench
======================================

# pipo_load_sequencer

Control FSM that sequences a bank of NREG signed PIPO operand registers and one PIPO result register around a multi-cycle arithmetic datapath. It loads operands one by one from a shared input bus, pulses the datapath start, waits for completion, and enables the result register. It sits between the user-input interface (switch/button-derived strobes) and the operand/result register bank. It does not hold data itself; the bank takes `i_data` directly.

## Interface
- `NREG`, default 2: number of operand registers sequenced; minimum 2.
- `TO_CYC`, default 16: datapath timeout in BUSY cycles. Used only with the timeout feature.
- `IW`, default `$clog2(NREG)`: index width (derived, not overridden).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  begin a load/compute sequence; sampled only in IDLE.
- `i_valid`  in  1  operand present on shared bus; sampled only in LOAD.
- `i_dp_done`  in  1  datapath completion strobe; sampled only in BUSY.
- `o_en`  out  NREG  one-hot operand-register enable; bit `idx` drives `pipo.en` of operand `idx`.
- `o_dp_start`  out  1  one-cycle datapath start pulse.
- `o_res_en`  out  1  one-cycle result-register enable.
- `o_ready`  out  1  high in IDLE.
- `o_busy`  out  1  high in LOAD, START, BUSY and CAPTURE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_idx`  out  IW  index of the operand currently awaited.
- `o_timeout`  out  1  one-cycle timeout pulse; constant 0 when the feature is compiled out.

## Operation
- States: IDLE, LOAD, START, BUSY, CAPTURE, DONE. The state register, `idx` and the timeout counter are registered. Outputs are decoded from state, except `o_en`.
- `o_en = (state==LOAD && i_valid) ? (1<<idx) : 0` is combinational, so the operand register captures `i_data` on the same edge that the FSM advances.
- IDLE: `o_ready`=1. If `i_start`=1, go to LOAD and set `idx`=0. Otherwise stay.
- LOAD: each cycle with `i_valid`=1 loads operand `idx`. If `idx`==NREG-1, go to START. Otherwise increment `idx`. Cycles with `i_valid`=0 hold state and `idx`.
- START: `o_dp_start`=1 for exactly one cycle, then go to BUSY. Clear the timeout counter.
- BUSY: if `i_dp_done`=1, go to CAPTURE. Otherwise stay.
- CAPTURE: `o_res_en`=1 for one cycle, then go to DONE.
- DONE: `o_done`=1 for one cycle, then go to IDLE and clear `idx`.
- Ignored inputs:
  - `i_start` outside IDLE.
  - `i_valid` outside LOAD.
  - `i_dp_done` outside BUSY.
- `i_start` held high across DONE→IDLE restarts a new sequence on the next cycle.
- Reset (asynchronous, any state): state=IDLE, `idx`=0, counter=0.
  - Outputs after reset: `o_ready`=1, all others 0, `o_en`=0.
  - Reset mid-sequence abandons it. Register-bank contents are governed by their own reset.

## Timing
Reference case: NREG=2, `i_start` high in cycle 0, `i_valid` high in cycles 1–2.
- LOAD in cycles 1–2. `o_en`=01 in cycle 1 and 10 in cycle 2.
- START in cycle 3, with `o_dp_start` high.
- BUSY from cycle 4.
- `i_dp_done` in cycle k≥4 gives CAPTURE in k+1, DONE in k+2 and IDLE in k+3.
- Minimum sequence is 3 + NREG + 1 cycles from `i_start` to `o_done`, with valid every cycle and done in the first BUSY cycle.
- `o_dp_start`, `o_res_en`, `o_done` and `o_timeout` are never high for more than one consecutive cycle.

## Configuration
- `PIPO_SEQ_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TO_CYC+1)` increments each BUSY cycle without `i_dp_done`.
  - On the cycle the count equals TO_CYC-1 with `i_dp_done`=0, `o_timeout` pulses, the FSM goes directly to IDLE, and CAPTURE/DONE are skipped.
  - `i_dp_done` in that same cycle wins: go to CAPTURE with no timeout.
- `PIPO_SEQ_TIMEOUT_EN` undefined: no counter is present, `o_timeout`=0, and BUSY waits indefinitely.

## Test plan
- Reset check: assert `rst`=0 mid-BUSY. Required response:
  - State IDLE immediately (asynchronous).
  - `o_ready`=1, all other outputs 0.
  - After release, `o_idx`=0.
- Nominal sequence, NREG=2, with `i_data`=-3 then 7:
  - `o_en`=01 then 10 on consecutive cycles; the bank holds -3 and 7.
  - `o_dp_start` in cycle 3.
  - `i_dp_done` in cycle 6 gives `o_res_en` in cycle 7, `o_done` in cycle 8 and `o_ready` in cycle 9.
- Gapped valid: `i_valid` pattern 1,0,0,1. Required: `o_idx` holds at 1 for the two idle cycles, `o_en` stays 0 during the gaps, and START follows the second valid.
- Ignored inputs:
  - `i_start` pulses during LOAD/BUSY do not restart the sequence.
  - `i_dp_done` during LOAD does not advance the FSM.
  - `i_valid` in BUSY gives `o_en`=0.
- Timeout, TO_CYC=4, macro defined, `i_dp_done` never asserted: `o_timeout` pulses in the 4th BUSY cycle, then IDLE, with no `o_res_en` and no `o_done`. Repeat with `i_dp_done` in the 4th BUSY cycle: CAPTURE follows and no timeout occurs.
- Back-to-back: `i_start` held high throughout. Required: second sequence enters LOAD the cycle after IDLE, and `o_idx` restarts at 0.

Source files
------------

// File: rtl/pipo_load_sequencer.sv
// -----------------------------------------------------------------------------
// pipo_load_sequencer
//
// Control FSM that steps a bank of NREG signed PIPO operand registers and one
// PIPO result register around a multi-cycle arithmetic datapath. Operands are
// loaded one at a time from a shared input bus. The datapath start is then
// pulsed, the FSM waits for completion, and the result register is enabled.
// This block holds no data. The register bank takes the input bus directly and
// is enabled by o_en / o_res_en.
//
// Optional feature (compile-time macro PIPO_SEQ_TIMEOUT_EN):
//   When defined, a BUSY-cycle counter aborts the wait after TO_CYC cycles.
//   It pulses o_timeout and returns straight to IDLE.
//   When undefined, no counter exists, o_timeout is tied to 0, and BUSY waits
//   indefinitely.
//
// Parameters:
//   NREG    number of operand registers sequenced (minimum 2)
//   TO_CYC  datapath timeout in BUSY cycles (used only with the timeout macro)
//   IW      index width, derived as $clog2(NREG)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous, active-low reset
//   i_start     begin a load/compute sequence (sampled only in IDLE)
//   i_valid     operand present on the shared bus (sampled only in LOAD)
//   i_dp_done   datapath completion strobe (sampled only in BUSY)
//   o_en        one-hot operand-register enable; combinational
//   o_dp_start  one-cycle datapath start pulse
//   o_res_en    one-cycle result-register enable
//   o_ready     high in IDLE
//   o_busy      high in LOAD, START, BUSY and CAPTURE
//   o_done      one-cycle completion pulse
//   o_idx       index of the operand currently awaited
//   o_timeout   one-cycle timeout pulse (0 when the feature is compiled out)
// -----------------------------------------------------------------------------
module pipo_load_sequencer #(
  parameter  int NREG   = 2,
  parameter  int TO_CYC = 16,
  localparam int IW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_valid,
  input  logic            i_dp_done,
  output logic [NREG-1:0] o_en,
  output logic            o_dp_start,
  output logic            o_res_en,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_done,
  output logic [IW-1:0]   o_idx,
  output logic            o_timeout
);

  // Elaboration-time sanity check on the configuration.
  if (NREG < 2 || TO_CYC < 1) begin : g_param_check
    $error("pipo_load_sequencer: NREG must be >= 2 and TO_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_BUSY,
    S_CAPTURE,
    S_DONE
  } state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(NREG - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;

  // The status/strobe outputs are registered. Each is decoded from the next
  // state, so the flop value always matches the current state.
  logic ready_q,    ready_d;
  logic busy_q,     busy_d;
  logic dp_start_q, dp_start_d;
  logic res_en_q,   res_en_d;
  logic done_q,     done_d;

  // Timeout for the current cycle. It depends on i_dp_done, because a
  // completion arriving in the final counted cycle must suppress it.
  logic timeout;

`ifdef PIPO_SEQ_TIMEOUT_EN
  localparam int            CW       = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    timeout = 1'b0;
`ifdef PIPO_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end

      S_LOAD: begin
        // A cycle without i_valid holds both the state and the index.
        if (i_valid) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_START;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_START: begin
        state_d = S_BUSY;
`ifdef PIPO_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      S_BUSY: begin
        if (i_dp_done) begin
          state_d = S_CAPTURE;
        end
`ifdef PIPO_SEQ_TIMEOUT_EN
        // The count equals the number of BUSY cycles already spent. It reaches
        // TO_CYC-1 in the TO_CYC-th BUSY cycle.
        else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end

      S_CAPTURE: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state (registered in the flop block below)
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_d    = (state_d == S_IDLE);
    busy_d     = (state_d == S_LOAD)  || (state_d == S_START) ||
                 (state_d == S_BUSY)  || (state_d == S_CAPTURE);
    dp_start_d = (state_d == S_START);
    res_en_d   = (state_d == S_CAPTURE);
    done_d     = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      dp_start_q <= 1'b0;
      res_en_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef PIPO_SEQ_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      dp_start_q <= dp_start_d;
      res_en_q   <= res_en_d;
      done_q     <= done_d;
`ifdef PIPO_SEQ_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // o_en is combinational on purpose. The operand register captures the bus on
  // the same edge that the FSM advances to the next index.
  assign o_en       = (state_q == S_LOAD && i_valid) ? (NREG'(1) << idx_q) : '0;
  assign o_dp_start = dp_start_q;
  assign o_res_en   = res_en_q;
  assign o_ready    = ready_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_idx      = idx_q;

`ifdef PIPO_SEQ_TIMEOUT_EN
  assign o_timeout  = timeout;
`else
  assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_pipo_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipo_load_sequencer
//
// Self-checking bench for pipo_load_sequencer (NREG=2, TO_CYC=4).
//
// Each sequence is described by a small set of numbers:
//   - the idle gap before each operand,
//   - the number of BUSY cycles before i_dp_done,
//   - whether unrelated inputs are toggled.
// The expected outputs for every cycle are derived from the phase order
// IDLE -> operands -> start -> wait -> capture -> done.
//
// A bench-side operand bank captures i_data through o_en, so the loaded values
// can be compared against what was sent.
// -----------------------------------------------------------------------------
module tb_pipo_load_sequencer;

  localparam int NREG   = 2;
  localparam int TO_CYC = 4;
  localparam int IW     = $clog2(NREG);

`ifdef PIPO_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Flag vector order: {ready, busy, dp_start, res_en, done, timeout}
  localparam logic [5:0] F_READY = 6'b100000;
  localparam logic [5:0] F_BUSY  = 6'b010000;
  localparam logic [5:0] F_START = 6'b001000;
  localparam logic [5:0] F_RES   = 6'b000100;
  localparam logic [5:0] F_DONE  = 6'b000010;
  localparam logic [5:0] F_TO    = 6'b000001;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_start = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_dp_done = 1'b0;
  logic [NREG-1:0] o_en;
  logic            o_dp_start;
  logic            o_res_en;
  logic            o_ready;
  logic            o_busy;
  logic            o_done;
  logic [IW-1:0]   o_idx;
  logic            o_timeout;

  logic signed [7:0] i_data = '0;
  logic signed [7:0] bank [NREG];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipo_load_sequencer #(.NREG(NREG), .TO_CYC(TO_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_valid    (i_valid),
    .i_dp_done  (i_dp_done),
    .o_en       (o_en),
    .o_dp_start (o_dp_start),
    .o_res_en   (o_res_en),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_idx      (o_idx),
    .o_timeout  (o_timeout)
  );

  // Bench-side operand bank, enabled by the DUT's one-hot o_en.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NREG; j++) begin
      if (o_en[j]) bank[j] <= i_data;
    end
  end

  function automatic logic [5:0] flags();
    return {o_ready, o_busy, o_dp_start, o_res_en, o_done, o_timeout};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_bit(input bit en, output logic b);
    b = en ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // Checks one cycle's outputs at the falling edge, then advances to just
  // after the next rising edge.
  task automatic cycle_check(input string tag, input logic [5:0] exp_flags,
                             input logic [NREG-1:0] exp_en, input int exp_idx,
                             input bit chk_idx);
    @(negedge clk);
    check({tag, ".flags"}, 32'(flags()), 32'(exp_flags));
    check({tag, ".en"}, 32'(o_en), 32'(exp_en));
    if (chk_idx) check({tag, ".idx"}, 32'(o_idx), 32'(exp_idx));
    tick();
  endtask

  // Idle cycles with i_start low and random stray inputs.
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      i_start = 1'b0;
      rnd_bit(1'b1, i_valid);
      rnd_bit(1'b1, i_dp_done);
      cycle_check("idle", F_READY, '0, 0, 1'b1);
    end
  endtask

  // One complete sequence, starting in an IDLE cycle.
  //   gap0/gap1  : invalid cycles before operand 0 / operand 1
  //   done_after : BUSY cycles without i_dp_done before it is asserted
  //   noise      : toggle the inputs that this phase must ignore
  //   hold_start : keep i_start high throughout
  task automatic run_seq(input int gap0, input int gap1, input int done_after,
                         input bit noise, input bit hold_start,
                         input logic signed [7:0] d0, input logic signed [7:0] d1);
    int  gap;
    bit  exp_to;
    logic sn;

    // IDLE: i_start launches the sequence.
    i_start = 1'b1;
    rnd_bit(noise, i_valid);
    rnd_bit(noise, i_dp_done);
    cycle_check("seq_idle", F_READY, '0, 0, 1'b1);

    // Operand loading.
    for (int j = 0; j < NREG; j++) begin
      gap = (j == 0) ? gap0 : gap1;
      for (int g = 0; g < gap; g++) begin
        rnd_bit(noise, sn);
        i_start = hold_start | sn;
        i_valid = 1'b0;
        rnd_bit(noise, i_dp_done);
        cycle_check("load_gap", F_BUSY, '0, j, 1'b1);
      end
      rnd_bit(noise, sn);
      i_start = hold_start | sn;
      i_valid = 1'b1;
      i_data  = (j == 0) ? d0 : d1;
      rnd_bit(noise, i_dp_done);
      cycle_check("load_valid", F_BUSY, NREG'(1) << j, j, 1'b1);
    end

    // START.
    rnd_bit(noise, sn);
    i_start = hold_start | sn;
    rnd_bit(noise, i_valid);
    rnd_bit(noise, i_dp_done);
    cycle_check("start", F_BUSY | F_START, '0, 0, 1'b0);

    // BUSY: i_dp_done arrives in BUSY cycle index done_after, unless the
    // timeout fires first in cycle index TO_CYC-1.
    for (int b = 0; b <= done_after; b++) begin
      rnd_bit(noise, sn);
      i_start   = hold_start | sn;
      rnd_bit(noise, i_valid);
      i_dp_done = (b == done_after);
      exp_to    = TO_EN && (b == TO_CYC - 1) && (b != done_after);
      cycle_check("busy", exp_to ? (F_BUSY | F_TO) : F_BUSY, '0, 0, 1'b0);
      if (exp_to) return;
    end

    // CAPTURE and DONE.
    rnd_bit(noise, sn);
    i_start = hold_start | sn;
    rnd_bit(noise, i_valid);
    rnd_bit(noise, i_dp_done);
    cycle_check("capture", F_BUSY | F_RES, '0, 0, 1'b0);
    rnd_bit(noise, sn);
    i_start = hold_start | sn;
    rnd_bit(noise, i_valid);
    rnd_bit(noise, i_dp_done);
    cycle_check("done", F_DONE, '0, 0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset.
    #12 rst = 1'b1;
    tick();
    cycle_check("por", F_READY, '0, 0, 1'b1);

    // Nominal sequence: -3 then 7, done in the third BUSY cycle.
    // This puts o_dp_start in cycle 3, o_res_en in 7, o_done in 8 and IDLE in 9.
    run_seq(0, 0, 2, 1'b0, 1'b0, -8'sd3, 8'sd7);
    check("bank0", 32'(bank[0]), 32'(-3));
    check("bank1", 32'(bank[1]), 32'(7));
    idle_cycles(2);

    // Gapped valid: pattern 1,0,0,1.
    run_seq(0, 2, 0, 1'b0, 1'b0, 8'sd25, -8'sd100);
    check("gap_bank0", 32'(bank[0]), 32'(25));
    check("gap_bank1", 32'(bank[1]), 32'(-100));
    idle_cycles(1);

    // Ignored inputs: stray start/valid/done in every phase.
    run_seq(1, 1, 3, 1'b1, 1'b0, 8'sd1, 8'sd2);
    idle_cycles(1);

    // Long wait with no done: times out in the 4th BUSY cycle when the
    // feature is built, otherwise completes normally after the wait.
    run_seq(0, 0, 10, 1'b0, 1'b0, 8'sd9, 8'sd10);
    idle_cycles(2);
    // Done in the 4th BUSY cycle wins over the timeout.
    run_seq(0, 0, TO_CYC - 1, 1'b0, 1'b0, 8'sd11, 8'sd12);
    idle_cycles(1);

    // Back-to-back with i_start held high.
    run_seq(0, 1, 1, 1'b0, 1'b1, 8'sd3, 8'sd4);
    run_seq(0, 0, 0, 1'b0, 1'b1, 8'sd5, 8'sd6);
    idle_cycles(1);

    // Asynchronous reset mid-BUSY.
    i_start = 1'b1; i_valid = 1'b0; i_dp_done = 1'b0;
    tick();                              // IDLE -> LOAD
    i_start = 1'b0; i_valid = 1'b1;
    tick();                              // idx 0 loaded
    tick();                              // idx 1 loaded -> START
    i_valid = 1'b0;
    tick();                              // -> BUSY
    tick();                              // second BUSY cycle
    i_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_flags", 32'(flags()), 32'(F_READY));
    check("rst_en", 32'(o_en), 32'(0));
    check("rst_idx", 32'(o_idx), 32'(0));
    tick();
    #3 rst = 1'b1;
    i_valid = 1'b0;
    tick();
    cycle_check("post_rst", F_READY, '0, 0, 1'b1);

    // Randomized sequences.
    for (int n = 0; n < 20; n++) begin
      run_seq($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6),
              1'b1, 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
